// File: rtl/bytewrite_stream_packer_pkg.sv
// Shared types and sizing helpers for the byte-column stream packer.
// Holds the FSM state encoding and the width derivations used by the packer.
package bytewrite_stream_packer_pkg;

  localparam int NUM_COL_DEFAULT    = 2;
  localparam int COL_WIDTH_DEFAULT  = 8;
  localparam int ADDR_WIDTH_DEFAULT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int data_width(input int num_col, input int col_width);
    return num_col * col_width;
  endfunction

  // A single-column word still needs a one-bit column index.
  function automatic int col_idx_width(input int num_col);
    return (num_col > 1) ? $clog2(num_col) : 1;
  endfunction

endpackage

// File: rtl/bytewrite_stream_packer.sv
// Packs a byte-column valid/ready stream into little-endian RAM words and drives
// the write port of a byte-write simple-dual-port RAM with auto-incrementing addresses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; stream not accepted
// ST_PACK | accepting beats, one RAM write per completed word
// ST_DONE | final write visible on the RAM port; done pulses
module bytewrite_stream_packer
  import bytewrite_stream_packer_pkg::*;
#(
  parameter int NUM_COL    = NUM_COL_DEFAULT,
  parameter int COL_WIDTH  = COL_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = data_width(NUM_COL, COL_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [COL_WIDTH-1:0]  s_data,
  input  logic                  s_last,
  output logic                  ram_ena,
  output logic [NUM_COL-1:0]    ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  wrapped
);

  localparam int CW = col_idx_width(NUM_COL);
  localparam logic [CW-1:0]     LAST_COL = CW'(NUM_COL - 1);
  localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state, state_next;
  logic [CW-1:0]           col;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   shadow;
  logic [NUM_COL-1:0]      mask;
  logic                    accept;
  logic                    complete;
  logic [DATA_WIDTH-1:0]   beat_word;
  logic [NUM_COL-1:0]      beat_mask;

  assign s_ready   = (state == ST_PACK);
  assign busy      = (state != ST_IDLE);
  // The DONE cycle is exactly the cycle the final registered write is on the port.
  assign done      = (state == ST_DONE);
  assign accept    = s_valid && s_ready;
  assign complete  = accept && ((col == LAST_COL) || s_last);
  assign beat_word = DATA_WIDTH'(s_data) << (int'(col) * COL_WIDTH);
  assign beat_mask = NUM_COL'(1) << col;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_PACK;
      ST_PACK: if (complete && s_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_ena        <= 1'b0;
      ram_we         <= '0;
      ram_write_addr <= '0;
      ram_din        <= '0;
      word_count     <= '0;
      wrapped        <= 1'b0;
      col            <= '0;
      ptr            <= '0;
      shadow         <= '0;
      mask           <= '0;
    end else begin
      ram_ena <= 1'b0;
      if (state == ST_IDLE && start) begin
        ptr        <= base_addr;
        col        <= '0;
        shadow     <= '0;
        mask       <= '0;
        word_count <= '0;
        wrapped    <= 1'b0;
      end else if (accept) begin
        if (complete) begin
          ram_ena        <= 1'b1;
          ram_we         <= mask | beat_mask;
          ram_write_addr <= ptr;
          ram_din        <= shadow | beat_word;
          ptr            <= ptr + 1'b1;
          col            <= '0;
          shadow         <= '0;
          mask           <= '0;
          if (word_count != WC_MAX) word_count <= word_count + 1'b1;
          if (ptr == '1)            wrapped    <= 1'b1;
        end else begin
          shadow <= shadow | beat_word;
          mask   <= mask | beat_mask;
          col    <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bytewrite_stream_packer.sv
// Directed bench for bytewrite_stream_packer: stimulus pushes expected RAM writes
// into a queue, a negedge monitor pops and compares each write the DUT issues.
module tb_bytewrite_stream_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  base_addr;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        ram_ena;
  logic [1:0]  ram_we;
  logic [8:0]  ram_write_addr;
  logic [15:0] ram_din;
  logic        busy;
  logic        done;
  logic [9:0]  word_count;
  logic        wrapped;

  bytewrite_stream_packer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_write_addr(ram_write_addr),
    .ram_din(ram_din), .busy(busy), .done(done), .word_count(word_count),
    .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] din;
    logic [1:0]  we;
    logic        dn;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!ram_ena && done) begin
        total++;
        bad++;
        $display("FAIL done_without_write: done=1 ram_ena=0 at cycle %0d", cyc);
      end
      if (ram_ena) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_write: addr=0x%0h din=0x%0h we=%b, expected no write",
                   ram_write_addr, ram_din, ram_we);
        end else begin
          e = q.pop_front();
          chk("wr_addr",  32'(ram_write_addr), 32'(e.addr));
          chk("wr_din",   32'(ram_din),        32'(e.din));
          chk("wr_we",    32'(ram_we),         32'(e.we));
          chk("wr_done",  32'(done),           32'(e.dn));
          chk("wr_cycle", cyc,                 e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [8:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
  endtask

  // Presents one beat until accepted; when it completes a word the expected write
  // (visible the cycle after the accepting edge) is queued.
  task automatic send(input logic [7:0] d, input bit last, input bit wr,
                      input logic [8:0] a, input logic [15:0] din,
                      input logic [1:0] we, input bit dn);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!acc && n < 20) begin
      acc = s_ready;
      tick();
      n++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'hEE;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: data=0x%0h not accepted within 20 cycles", d);
    end else if (wr) begin
      q.push_back('{a, din, we, dn, cyc});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    tick(); tick();
    chk("rst_ena",   32'(ram_ena),        0);
    chk("rst_we",    32'(ram_we),         0);
    chk("rst_addr",  32'(ram_write_addr), 0);
    chk("rst_din",   32'(ram_din),        0);
    chk("rst_busy",  32'(busy),           0);
    chk("rst_done",  32'(done),           0);
    chk("rst_wc",    32'(word_count),     0);
    chk("rst_wrap",  32'(wrapped),        0);
    chk("rst_ready", 32'(s_ready),        0);
    rst = 1'b0;
    tick();

    // Frame 1: two full words
    do_start(9'h010);
    chk("t1_busy",  32'(busy),    1);
    chk("t1_ready", 32'(s_ready), 1);
    send(8'hA1, 0, 0, 0, 0, 0, 0);
    send(8'hB2, 0, 1, 9'h010, 16'hB2A1, 2'b11, 0);
    send(8'hC3, 0, 0, 0, 0, 0, 0);
    send(8'hD4, 1, 1, 9'h011, 16'hD4C3, 2'b11, 1);
    chk("t1_done",  32'(done),    1);
    chk("t1_ready_done", 32'(s_ready), 0);
    tick(); tick();
    chk("t1_wc",    32'(word_count), 2);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_wrap",  32'(wrapped), 0);

    // Stream activity while IDLE must be ignored
    s_valid = 1'b1; s_data = 8'h99; s_last = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("idle_ignore_wc", 32'(word_count), 2);

    // Frame 2: odd beat count, partial final word
    do_start(9'h020);
    send(8'h11, 0, 0, 0, 0, 0, 0);
    send(8'h22, 0, 1, 9'h020, 16'h2211, 2'b11, 0);
    send(8'h33, 1, 1, 9'h021, 16'h0033, 2'b01, 1);
    chk("t2_done", 32'(done), 1);
    tick(); tick();
    chk("t2_wc", 32'(word_count), 2);

    // Frame 3: address wrap
    do_start(9'h1FF);
    send(8'h01, 0, 0, 0, 0, 0, 0);
    send(8'h02, 0, 1, 9'h1FF, 16'h0201, 2'b11, 0);
    send(8'h03, 0, 0, 0, 0, 0, 0);
    send(8'h04, 1, 1, 9'h000, 16'h0403, 2'b11, 1);
    tick(); tick();
    chk("t3_wrap", 32'(wrapped), 1);
    chk("t3_wc",   32'(word_count), 2);

    // Frame 4: valid gaps inside a word
    do_start(9'h050);
    chk("t4_wrap_cleared", 32'(wrapped), 0);
    send(8'h5A, 0, 0, 0, 0, 0, 0);
    idle(2);
    send(8'hA5, 1, 1, 9'h050, 16'hA55A, 2'b11, 1);
    tick(); tick();
    chk("t4_wc", 32'(word_count), 1);

    // Frame 5: reset mid-word discards the partial word
    do_start(9'h080);
    send(8'h77, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk("t5_ena",   32'(ram_ena),    0);
    chk("t5_busy",  32'(busy),       0);
    chk("t5_ready", 32'(s_ready),    0);
    chk("t5_wc",    32'(word_count), 0);
    rst = 1'b0;
    idle(3);

    // Frame 6: start pulsed during PACK and DONE is ignored
    do_start(9'h0C0);
    send(8'h10, 0, 0, 0, 0, 0, 0);
    start = 1'b1; base_addr = 9'h1AA;
    send(8'h20, 0, 1, 9'h0C0, 16'h2010, 2'b11, 0);
    send(8'h30, 1, 1, 9'h0C1, 16'h0030, 2'b01, 1);
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t6_busy", 32'(busy),       0);
    chk("t6_wc",   32'(word_count), 2);

    idle(3);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
